// File: rtl/rx_deserializer.sv
// UART receive deserializer: samples data bits mid-bit after a verified
// start, assembles the word LSB-first, checks the stop bit, then re-arms
// the start-bit detector.
//
// Ports:
//   clk_i       oversampling clock (OVS cycles per bit)
//   rst_i       synchronous active-high reset
//   rx_i        synchronized serial line, idle high
//   start_i     verified-start level from the detector
//   data_o      last correctly framed word, held between frames
//   valid_o     one-cycle pulse when data_o updates
//   frame_err_o one-cycle pulse when the stop bit reads low
//   busy_o      high while a frame is in progress
//   det_rst_o   one-cycle pulse that clears the detector's start flag
module rx_deserializer #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic                 start_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o,
    output logic                 det_rst_o
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        DONE
    } state_e;

    localparam logic [4:0] CNT_MAX  = 5'(OVS - 1);
    localparam logic [3:0] IDX_LAST = 4'(DATA_BITS - 1);

    state_e               state_q;
    logic [4:0]           cnt_q;
    logic [4:0]           cnt_d;
    logic [3:0]           idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 drst_q;
    logic                 bit_tick;

    // The start flag is first seen at mid start bit, so counting a full
    // bit period from there lands every later sample at mid bit.
    assign bit_tick = (cnt_q == CNT_MAX);
    assign cnt_d    = bit_tick ? 5'd0 : cnt_q + 5'd1;
    // LSB arrives first: shifting right leaves it at bit 0 once full.
    assign shift_d  = {rx_i, shift_q[DATA_BITS-1:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            drst_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            drst_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_tick) begin
                        shift_q <= shift_d;
                        idx_q   <= idx_q + 4'd1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_tick) begin
                        if (rx_i) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        // Pulses land in the DONE cycle together.
                        drst_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = busy_q;
    assign det_rst_o   = drst_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer with a behavioural start detector.
// Frames are driven on a timeline relative to E0 (first edge start_i=1).
module tb_rx_deserializer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic       start_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;
    logic       det_rst_o;

    logic       trig;
    logic       kill;
    logic       flag_q;

    int checks = 0;
    int errors = 0;
    int n_val  = 0;
    int n_err  = 0;
    int n_det  = 0;
    int n_both = 0;
    logic [7:0] last_good;

    always #5 clk_i = ~clk_i;

    rx_deserializer #(
        .DATA_BITS(8),
        .OVS(16)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .rx_i(rx_i),
        .start_i(start_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .frame_err_o(frame_err_o),
        .busy_o(busy_o),
        .det_rst_o(det_rst_o)
    );

    // Detector model: latched flag, cleared by reset or re-arm pulse.
    always @(posedge clk_i) begin
        if (rst_i || det_rst_o) flag_q <= 1'b0;
        else if (trig) flag_q <= 1'b1;
    end
    assign start_i = flag_q & ~kill;

    always @(negedge clk_i) begin
        if (valid_o) n_val++;
        if (frame_err_o) n_err++;
        if (det_rst_o) n_det++;
        if (valid_o && frame_err_o) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Line level at offset n from E0; bit boundaries shifted by +/-jit.
    function automatic logic line_val(input int n, input logic [7:0] d,
                                      input logic stp, input int jit);
        int b;
        b = 8 - jit;
        if (n < -8) return 1'b1;
        if (n < b) return 1'b0;
        for (int k = 0; k < 8; k++) begin
            b = 8 + 16 * (k + 1) + (((k % 2) == 0) ? jit : -jit);
            if (n < b) return d[k];
        end
        if (n < 152) return stp;
        return 1'b1;
    endfunction

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) begin
            @(negedge clk_i);
            rx_i = 1'b1;
        end
    endtask

    task automatic frame(input string nm, input logic [7:0] d,
                         input logic stp, input int jit,
                         input int rst_at, input int kill_at);
        logic [7:0] expd;
        expd = stp ? d : last_good;
        for (int n = -8; n <= 146; n++) begin
            @(negedge clk_i);
            // Outputs here reflect edge n-1.
            if (n == 0) chk({nm, " busy_pre"}, busy_o, 0);
            if (n == 1) chk({nm, " busy_rise"}, busy_o, 1);
            if (n == 144) chk({nm, " early_pulse"},
                              {valid_o, frame_err_o, det_rst_o}, 0);
            if (n == 145) begin
                chk({nm, " valid"}, valid_o, stp);
                chk({nm, " ferr"}, frame_err_o, !stp);
                chk({nm, " det_rst"}, det_rst_o, 1);
                chk({nm, " data"}, data_o, expd);
                chk({nm, " busy_done"}, busy_o, 1);
            end
            if (n == 146) begin
                chk({nm, " valid_end"}, valid_o, 0);
                chk({nm, " det_end"}, det_rst_o, 0);
                chk({nm, " busy_fall"}, busy_o, 0);
                chk({nm, " start_clr"}, start_i, 0);
            end
            if (rst_at >= 0 && n == rst_at + 1) begin
                chk({nm, " rst_data"}, data_o, 0);
                chk({nm, " rst_flags"},
                    {valid_o, frame_err_o, det_rst_o, busy_o}, 0);
                rst_i = 1'b0;
                kill  = 1'b0;
                last_good = 8'h00;
                return;
            end
            rx_i  = line_val(n, d, stp, jit);
            trig  = (n == -1);
            kill  = (kill_at >= 0 && n >= kill_at);
            rst_i = (rst_at >= 0 && n == rst_at);
        end
        kill = 1'b0;
        if (stp) last_good = d;
    endtask

    int bv, be, bd;

    initial begin
        rst_i     = 1'b1;
        rx_i      = 1'b1;
        trig      = 1'b0;
        kill      = 1'b0;
        last_good = 8'h00;
        repeat (3) @(negedge clk_i);
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_det", det_rst_o, 0);
        rst_i = 1'b0;
        idle(20);

        frame("a5", 8'hA5, 1'b1, 0, -1, -1);
        idle(20);

        frame("11", 8'h11, 1'b1, 0, -1, -1);
        idle(20);
        frame("3c_err", 8'h3C, 1'b0, 0, -1, -1);
        idle(20);

        @(posedge clk_i);
        bv = n_val;
        bd = n_det;
        frame("b2b_00", 8'h00, 1'b1, 0, -1, -1);
        idle(16);
        frame("b2b_ff", 8'hFF, 1'b1, 0, -1, -1);
        idle(4);
        @(posedge clk_i);
        chk("b2b_valid_cnt", n_val - bv, 2);
        chk("b2b_det_cnt", n_det - bd, 2);

        bv = n_val;
        be = n_err;
        bd = n_det;
        frame("rst_mid", 8'h96, 1'b1, 0, 76, -1);
        idle(170);
        @(posedge clk_i);
        chk("rst_no_pulse", (n_val - bv) + (n_err - be) + (n_det - bd), 0);
        frame("5a", 8'h5A, 1'b1, 0, -1, -1);
        idle(20);

        frame("kill", 8'hC3, 1'b1, 0, -1, 40);
        idle(20);

        frame("jit01", 8'h01, 1'b1, 3, -1, -1);
        idle(20);
        frame("jit_b6", 8'hB6, 1'b1, -3, -1, -1);
        idle(20);

        @(posedge clk_i);
        chk("never_both", n_both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
